avm_wr_arbiter: RTL and testbench
=================================

AVM_WR_ARBITER -- requirements
Module: avm_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512: width of every avm write data bus.
REQ-002 SHALL have parameter BURST_LEN, default 16: beats per grant; legal range 1..256.
REQ-003 SHALL have parameter TIMEOUT, default 64: stall cycles before forced release (used only with AVM_ARB_TIMEOUT_EN); legal range 1..1023.
REQ-004 SHALL have port s_axi_aclk  in  1: single clock.
REQ-005 SHALL have port s_axi_aresetn  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports req0_wr_vaild  in  1 / req0_wr_data  in  DATA_WIDTH / req0_wr_ready  out  1: requester 0 stream.
REQ-007 SHALL have ports req1_wr_vaild  in  1 / req1_wr_data  in  DATA_WIDTH / req1_wr_ready  out  1: requester 1 stream.
REQ-008 SHALL have ports avm_wr_vaild  out  1 / avm_wr_data  out  DATA_WIDTH / avm_wr_ready  in  1: shared sink stream.
REQ-009 SHALL have port gnt_active  out  1: a grant is held.
REQ-010 SHALL have port gnt_id  out  1: index of the granted requester, valid while gnt_active=1.
REQ-011 SHALL have port burst_done  out  1: one-cycle pulse on completion of a full burst.
REQ-012 SHALL have port arb_timeout  out  1: one-cycle pulse on forced release.

Function
REQ-013 SHALL implement states IDLE, GNT0, GNT1; gnt_active=1 in GNT0/GNT1; gnt_id=1 only in GNT1.
REQ-014 In IDLE, SHALL move to GNTn on the next edge when any reqn_wr_vaild=1; no beat transfers in IDLE.
REQ-015 On simultaneous requests in IDLE, SHALL grant the requester selected by a round-robin pointer; a lone requester is granted regardless of pointer.
REQ-016 Pointer SHALL point to the requester not last granted; updated on every exit from GNTn.
REQ-017 In GNTn: avm_wr_vaild=reqn_wr_vaild, avm_wr_data=reqn_wr_data, reqn_wr_ready=avm_wr_ready, combinational, zero latency.
REQ-018 Non-granted requester ready SHALL be 0; avm_wr_vaild SHALL be 0 in IDLE; avm_wr_data SHALL be 0 when not granted.
REQ-019 A beat SHALL be counted only on vaild&ready of the granted stream; counter width clog2(BURST_LEN+1).
REQ-020 On the BURST_LEN-th beat, SHALL return to IDLE on that edge and pulse burst_done in the following cycle (coincident with IDLE).
REQ-021 Throughput SHALL be BURST_LEN beats per BURST_LEN+1 cycles under continuous demand; BURST_LEN=1 SHALL alternate grant/idle cycles.
REQ-022 Grant SHALL NOT change mid-burst when the granted requester drops vaild or the sink drops ready (burst atomic) unless REQ-026 applies.
REQ-023 arb_timeout SHALL be 0 constantly without AVM_ARB_TIMEOUT_EN.

Reset
REQ-024 On s_axi_aresetn=0, immediately (asynchronously): state IDLE, pointer to requester 0, beat and stall counters 0, burst_done=0, arb_timeout=0, all ready/vaild outputs 0.
REQ-025 Reset mid-burst SHALL abandon the burst without burst_done; first grant after release follows REQ-014/015.

Configuration
REQ-026 With AVM_ARB_TIMEOUT_EN defined: stall counter counts consecutive GNTn cycles with reqn_wr_vaild=0 (cycles with vaild=1, ready=0 do not count, reset counter); on reaching TIMEOUT, SHALL return to IDLE, update pointer, pulse arb_timeout next cycle, no burst_done.
REQ-027 Without AVM_ARB_TIMEOUT_EN: no stall counter is built, TIMEOUT is ignored, grant held until BURST_LEN beats complete.

Verification (BURST_LEN=4, TIMEOUT=8)
REQ-028 Only req0 valid continuously, sink ready=1 -> gnt_id=0, 4 beats, burst_done 1 cycle, 1 IDLE cycle, regrant req0; 8 beats in 10 cycles.
REQ-029 Both valid from reset -> grants 0,1,0,1; each 4 beats; data on avm_wr_data matches granted source beat-for-beat.
REQ-030 Granted req1, avm_wr_ready low for 20 cycles after beat 2 -> grant held, no arb_timeout, beats 3-4 complete after ready returns.
REQ-031 With macro: granted req0 drops vaild after beat 1 for 8 cycles -> arb_timeout pulse, IDLE, req1 granted next if valid; without macro -> grant held indefinitely.
REQ-032 Assert s_axi_aresetn=0 after beat 2 -> outputs 0 same cycle, no burst_done; after release both valid -> req0 granted first.

Source files
------------

// File: rtl/avm_wr_arbiter.sv
// ----------------------------------------------------------------------------
// avm_wr_arbiter
//   Two-requester write-stream arbiter onto one shared avm write sink.
//   A grant is held for BURST_LEN accepted beats. After that the arbiter spends
//   one cycle in IDLE and then re-arbitrates. When both requesters are valid in
//   IDLE, a round-robin pointer picks between them.
//   The data path is a zero-latency combinational mux steered by the state
//   register.
//
// Optional feature (compile-time macro AVM_ARB_TIMEOUT_EN):
//   If the granted requester drops vaild for TIMEOUT consecutive cycles, the
//   grant is released without waiting for the burst to finish, and arb_timeout
//   pulses. Without the macro no stall counter is built and TIMEOUT is ignored.
//
// Parameters:
//   DATA_WIDTH  width of every write data bus
//   BURST_LEN   beats per grant (1..256)
//   TIMEOUT     stall cycles before forced release (1..1023)
//
// Ports:
//   s_axi_aclk, s_axi_aresetn           clock, async active-low reset
//   req0_wr_vaild/_data/_ready          requester 0 stream (ready is output)
//   req1_wr_vaild/_data/_ready          requester 1 stream (ready is output)
//   avm_wr_vaild/_data/_ready           shared sink stream (ready is input)
//   gnt_active                          a grant is held
//   gnt_id                              granted requester index
//   burst_done                          1-cycle pulse after a full burst
//   arb_timeout                         1-cycle pulse after forced release
// ----------------------------------------------------------------------------
module avm_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned BURST_LEN  = 16,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,

   input  logic                  req0_wr_vaild,
   input  logic [DATA_WIDTH-1:0] req0_wr_data,
   output logic                  req0_wr_ready,

   input  logic                  req1_wr_vaild,
   input  logic [DATA_WIDTH-1:0] req1_wr_data,
   output logic                  req1_wr_ready,

   output logic                  avm_wr_vaild,
   output logic [DATA_WIDTH-1:0] avm_wr_data,
   input  logic                  avm_wr_ready,

   output logic                  gnt_active,
   output logic                  gnt_id,
   output logic                  burst_done,
   output logic                  arb_timeout
);

   localparam int unsigned      CNT_W     = $clog2(BURST_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GNT0 = 2'd1;
   localparam logic [1:0] ST_GNT1 = 2'd2;

   // Empty marker blocks. They make an out-of-range parameter easy to spot in
   // the elaborated hierarchy.
   if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_burst_len_out_of_range
   end
   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_timeout_out_of_range
   end

   logic [1:0]       state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] beat_q, beat_d;
   logic             burst_done_q, burst_done_d;
   logic             beat_c;

   // Grant-steered data path. Everything is forced to 0 when no grant is held.
   always_comb begin
      avm_wr_vaild  = 1'b0;
      avm_wr_data   = '0;
      req0_wr_ready = 1'b0;
      req1_wr_ready = 1'b0;
      case (state_q)
         ST_GNT0: begin
            avm_wr_vaild  = req0_wr_vaild;
            avm_wr_data   = req0_wr_data;
            req0_wr_ready = avm_wr_ready;
         end
         ST_GNT1: begin
            avm_wr_vaild  = req1_wr_vaild;
            avm_wr_data   = req1_wr_data;
            req1_wr_ready = avm_wr_ready;
         end
         default: ;
      endcase
   end

   // A beat is an accepted transfer on the granted stream. It is 0 in IDLE.
   assign beat_c = avm_wr_vaild & avm_wr_ready;

`ifdef AVM_ARB_TIMEOUT_EN
   localparam int unsigned       STALL_W    = $clog2(TIMEOUT + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               timeout_q, timeout_d;
`endif

   // Next-state logic: arbitration, beat counting, and (optional) stall release.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      beat_d       = beat_q;
      burst_done_d = 1'b0;
`ifdef AVM_ARB_TIMEOUT_EN
      stall_d      = stall_q;
      timeout_d    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
`ifdef AVM_ARB_TIMEOUT_EN
            stall_d = '0;
`endif
            if (req0_wr_vaild && req1_wr_vaild) begin
               state_d = ptr_q ? ST_GNT1 : ST_GNT0;
            end else if (req0_wr_vaild) begin
               state_d = ST_GNT0;
            end else if (req1_wr_vaild) begin
               state_d = ST_GNT1;
            end
         end
         ST_GNT0, ST_GNT1: begin
            // A beat needs vaild=1, so it can never coincide with a stall cycle.
            if (beat_c) begin
               if (beat_q == LAST_BEAT) begin
                  state_d      = ST_IDLE;
                  beat_d       = '0;
                  ptr_d        = (state_q == ST_GNT0);
                  burst_done_d = 1'b1;
               end else begin
                  beat_d = beat_q + CNT_W'(1);
               end
            end
`ifdef AVM_ARB_TIMEOUT_EN
            // Only cycles with vaild low count as stall. A sink back-pressure
            // cycle (vaild high) clears the stall count.
            if (avm_wr_vaild) begin
               stall_d = '0;
            end else if (stall_q == STALL_LAST) begin
               state_d   = ST_IDLE;
               beat_d    = '0;
               stall_d   = '0;
               ptr_d     = (state_q == ST_GNT0);
               timeout_d = 1'b1;
            end else begin
               stall_d = stall_q + STALL_W'(1);
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q      <= ST_IDLE;
         ptr_q        <= 1'b0;
         beat_q       <= '0;
         burst_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         beat_q       <= beat_d;
         burst_done_q <= burst_done_d;
      end
   end

`ifdef AVM_ARB_TIMEOUT_EN
   // Stall counter and timeout pulse register.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         stall_q   <= '0;
         timeout_q <= 1'b0;
      end else begin
         stall_q   <= stall_d;
         timeout_q <= timeout_d;
      end
   end

   assign arb_timeout = timeout_q;
`else
   assign arb_timeout = 1'b0;
`endif

   assign gnt_active = (state_q != ST_IDLE);
   assign gnt_id     = (state_q == ST_GNT1);
   assign burst_done = burst_done_q;

endmodule

// File: tb/tb_avm_wr_arbiter.sv
// Scoreboarded bench for avm_wr_arbiter with BURST_LEN=4, TIMEOUT=8.
// Expected beats {gnt_id, data} are queued when stimulus is driven. The
// monitor pops and compares one entry for each beat accepted by the sink.
module tb_avm_wr_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_v, req1_v, req0_rdy, req1_rdy;
   logic [DW-1:0] req0_d, req1_d;
   logic          avm_v, avm_rdy;
   logic [DW-1:0] avm_d;
   logic          gnt_active, gnt_id, burst_done, arb_timeout;

   logic [27:0]   seq0, seq1;
   logic          adv0, adv1;
   logic [32:0]   exp_q[$];
   int unsigned   beat_total;
   int unsigned   bb;
   logic          exp_done;
   int unsigned   n_cmp = 0;
   int unsigned   n_err = 0;
   int unsigned   cyc;

   always #5 clk = ~clk;

   assign req0_d = {4'h1, seq0};
   assign req1_d = {4'h2, seq1};

   avm_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO)) u_dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .req0_wr_vaild (req0_v),
      .req0_wr_data  (req0_d),
      .req0_wr_ready (req0_rdy),
      .req1_wr_vaild (req1_v),
      .req1_wr_data  (req1_d),
      .req1_wr_ready (req1_rdy),
      .avm_wr_vaild  (avm_v),
      .avm_wr_data   (avm_d),
      .avm_wr_ready  (avm_rdy),
      .gnt_active    (gnt_active),
      .gnt_id        (gnt_id),
      .burst_done    (burst_done),
      .arb_timeout   (arb_timeout)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic id, input logic [27:0] s);
      exp_q.push_back({id, (id ? 4'h2 : 4'h1), s});
   endtask

   task automatic push_range(input logic id, input int unsigned first, input int unsigned last);
      for (int i = int'(first); i <= int'(last); i++) push(id, 28'(i));
   endtask

   // Wait until beat_total reaches target, counting cycles. An expired budget
   // is reported as a failure.
   task automatic wait_beats(input int unsigned target, input int unsigned budget,
                             output int unsigned c);
      c = 0;
      while (beat_total < target && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("wait_budget", 64'(beat_total >= target), 64'd1);
   endtask

   task automatic settle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      req0_v = 1'b1; req1_v = 1'b1; avm_rdy = 1'b1;
      seq0 = '0; seq1 = '0;
      exp_q.delete();
      beat_total = 0;
      settle(2);
      check("rst_outputs",
            64'({gnt_active, gnt_id, burst_done, arb_timeout, avm_v, req0_rdy, req1_rdy, avm_d}),
            64'd0);
      req0_v = 1'b0; req1_v = 1'b0;
      rst_n = 1'b1;
   endtask

   // Requester model: move to the next data word after an accepted beat.
   always begin
      @(posedge clk); #1;
      if (adv0) seq0 = seq0 + 28'd1;
      if (adv1) seq1 = seq1 + 28'd1;
      adv0 = 1'b0;
      adv1 = 1'b0;
   end

   // Monitor, sampled mid-cycle: beat scoreboard, burst_done timing, idle quiet.
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst_n) begin
         bb = 0;
         exp_done = 1'b0;
      end else begin
         check("burst_done", 64'(burst_done), 64'(exp_done));
         if (exp_done) check("idle_after_burst", 64'(gnt_active), 64'd0);
`ifndef AVM_ARB_TIMEOUT_EN
         check("arb_timeout_low", 64'(arb_timeout), 64'd0);
`endif
         exp_done = 1'b0;
         if (!gnt_active) begin
            bb = 0;
            check("idle_quiet", 64'({avm_v, req0_rdy, req1_rdy, avm_d}), 64'd0);
         end else begin
            check("other_ready", 64'(gnt_id ? req0_rdy : req1_rdy), 64'd0);
         end
         if (avm_v && avm_rdy) begin
            beat_total++;
            if (gnt_id) adv1 = 1'b1; else adv0 = 1'b1;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               check("beat", 64'({gnt_id, avm_d}), 64'(e));
            end
            bb++;
            if (bb == BL) begin
               exp_done = 1'b1;
               bb = 0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req0_v = 1'b0; req1_v = 1'b0; avm_rdy = 1'b0;
      seq0 = '0; seq1 = '0; adv0 = 1'b0; adv1 = 1'b0;
      beat_total = 0; bb = 0; exp_done = 1'b0;

      // Lone req0, continuous: 8 beats in 10 cycles, one idle between bursts.
      do_reset();
      push_range(1'b0, 0, 7);
      req0_v = 1'b1;
      wait_beats(8, 40, cyc);
      check("thru_cycles", 64'(cyc), 64'd10);
      req0_v = 1'b0;
      settle(3);
      check("sb_empty_a", 64'(exp_q.size()), 64'd0);

      // Both valid from reset: grants 0,1,0,1 at 4 beats each.
      do_reset();
      push_range(1'b0, 0, 3); push_range(1'b1, 0, 3);
      push_range(1'b0, 4, 7); push_range(1'b1, 4, 7);
      req0_v = 1'b1; req1_v = 1'b1;
      wait_beats(16, 80, cyc);
      check("rr_cycles", 64'(cyc), 64'd20);
      req0_v = 1'b0; req1_v = 1'b0;
      settle(3);
      check("sb_empty_b", 64'(exp_q.size()), 64'd0);

      // req1 granted alone, sink stalls 20 cycles after beat 2.
      do_reset();
      push_range(1'b1, 0, 3);
      req1_v = 1'b1;
      wait_beats(2, 20, cyc);
      avm_rdy = 1'b0;
      settle(20);
      check("stall_hold", 64'({gnt_active, gnt_id, arb_timeout}), 64'b110);
      check("stall_beats", 64'(beat_total), 64'd2);
      avm_rdy = 1'b1;
      wait_beats(4, 20, cyc);
      req1_v = 1'b0;
      settle(3);
      check("sb_empty_c", 64'(exp_q.size()), 64'd0);

      // req0 drops vaild after beat 1 while req1 is waiting.
      do_reset();
      push(1'b0, 28'd0);
      req0_v = 1'b1;
      wait_beats(1, 20, cyc);
      req0_v = 1'b0; req1_v = 1'b1;
`ifdef AVM_ARB_TIMEOUT_EN
      push_range(1'b1, 0, 3);
      settle(TO);
      check("to_release", 64'({gnt_active, arb_timeout, burst_done}), 64'b010);
      settle(1);
      check("to_regrant", 64'({gnt_active, gnt_id, arb_timeout}), 64'b110);
      wait_beats(5, 20, cyc);
      req1_v = 1'b0;
`else
      settle(12);
      check("no_to_hold", 64'({gnt_active, gnt_id, arb_timeout}), 64'b100);
      check("no_to_beats", 64'(beat_total), 64'd1);
      push_range(1'b0, 1, 3); push_range(1'b1, 0, 3);
      req0_v = 1'b1;
      wait_beats(4, 20, cyc);
      req0_v = 1'b0;
      wait_beats(8, 20, cyc);
      req1_v = 1'b0;
`endif
      settle(3);
      check("sb_empty_d", 64'(exp_q.size()), 64'd0);

      // Reset asserted mid-burst after beat 2; req0 wins first after release.
      do_reset();
      push_range(1'b0, 0, 1);
      req0_v = 1'b1; req1_v = 1'b1;
      wait_beats(2, 20, cyc);
      rst_n = 1'b0;
      #1;
      check("async_rst", 64'({gnt_active, avm_v, req0_rdy, req1_rdy, avm_d}), 64'd0);
      settle(3);
      check("rst_no_done", 64'(burst_done), 64'd0);
      check("sb_empty_e0", 64'(exp_q.size()), 64'd0);
      push_range(1'b0, 2, 5);
      beat_total = 0;
      rst_n = 1'b1;
      wait_beats(4, 20, cyc);
      check("post_rst_cycles", 64'(cyc), 64'd5);
      req0_v = 1'b0; req1_v = 1'b0;
      settle(3);
      check("sb_empty_e", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
